// File: rtl/rf_ctrl_dump_clear.sv
// Initiator-side controller for the 8x8b 1r1w register file:
// forwards upstream writes, clears entries 1..7, or dumps all 8 entries.
module rf_ctrl_dump_clear (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       wr_val,
    output logic       wr_rdy,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [2:0] rf_read_addr,
    input  logic [7:0] rf_read_data,
    output logic       rf_write_en,
    output logic [2:0] rf_write_addr,
    output logic [7:0] rf_write_data,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [2:0] out_addr,
    output logic [7:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READ  = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic [2:0] LAST = 3'd7;

    state_t     state_q;
    logic [2:0] ptr_q;
    logic [7:0] data_q;
    logic       done_q;

    // Sequencer: command decode, clear walk and read/send beat loop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        ptr_q   <= 3'd1;
                    end else if (start) begin
                        state_q <= READ;
                        ptr_q   <= 3'd0;
                    end
                end
                CLEAR: begin
                    if (ptr_q == LAST) begin
                        state_q <= IDLE;
                        ptr_q   <= 3'd0;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 3'd1;
                    end
                end
                READ: begin
                    data_q  <= rf_read_data;
                    state_q <= SEND;
                end
                SEND: begin
                    if (out_rdy) begin
                        if (ptr_q == LAST) begin
                            state_q <= IDLE;
                            ptr_q   <= 3'd0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            ptr_q   <= ptr_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= 3'd0;
                end
            endcase
        end
    end

    // Write-port steering: upstream pass-through in IDLE, zero fill in CLEAR
    always_comb begin
        wr_rdy        = 1'b0;
        rf_write_en   = 1'b0;
        rf_write_addr = 3'd0;
        rf_write_data = 8'h00;
        unique case (state_q)
            IDLE: begin
                // Reset holds the upstream port closed so nothing
                // reaches the register file while reset is low.
                if (reset) begin
                    wr_rdy        = 1'b1;
                    rf_write_en   = wr_val;
                    rf_write_addr = wr_addr;
                    rf_write_data = wr_data;
                end
            end
            CLEAR: begin
                rf_write_en   = 1'b1;
                rf_write_addr = ptr_q;
            end
            default: begin
            end
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign rf_read_addr = ptr_q;
    assign out_val      = (state_q == SEND);
    assign out_addr     = ptr_q;
    assign out_data     = data_q;

endmodule

// File: tb/tb_rf_ctrl_dump_clear.sv
// Randomized self-checking bench for rf_ctrl_dump_clear against a
// shadow register array and an attached zero-register RF model.
module tb_rf_ctrl_dump_clear;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       start;
    logic       busy;
    logic       done;
    logic       wr_val;
    logic       wr_rdy;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rf_read_addr;
    logic [7:0] rf_read_data;
    logic       rf_write_en;
    logic [2:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       out_val;
    logic       out_rdy;
    logic [2:0] out_addr;
    logic [7:0] out_data;

    rf_ctrl_dump_clear dut (
        .clk          (clk),
        .reset        (reset),
        .clr          (clr),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .wr_val       (wr_val),
        .wr_rdy       (wr_rdy),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .rf_write_en  (rf_write_en),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_addr     (out_addr),
        .out_data     (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: entry 0 is hardwired to zero
    logic [7:0] mem [8] = '{default: 8'h00};
    always @(posedge clk)
        if (rf_write_en && rf_write_addr != 3'd0)
            mem[rf_write_addr] <= rf_write_data;
    assign rf_read_data =
        (rf_read_addr == 3'd0) ? 8'h00 : mem[rf_read_addr];

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Mid-cycle observer of beats, done pulses and busy writes
    logic [10:0] beats[$];
    logic [10:0] cq[$];
    int done_n   = 0;
    int done_cyc = 0;
    int bad_wr   = 0;
    always @(negedge clk) begin
        if (out_val && out_rdy) beats.push_back({out_addr, out_data});
        if (done) begin
            done_n   = done_n + 1;
            done_cyc = cyc_n;
        end
        if (rf_write_en && busy)
            cq.push_back({rf_write_addr, rf_write_data});
        if (wr_val && busy && wr_rdy) bad_wr = bad_wr + 1;
    end

    logic [7:0] sh [8];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_val  = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        chk("wr_rdy_idle", {31'd0, wr_rdy}, 1);
        tick();
        wr_val = 1'b0;
        if (a != 3'd0) sh[a] = d;
    endtask

    task automatic check_dump(input string tag, input int b0);
        chk({tag, "_nbeats"}, beats.size() - b0, 8);
        for (int j = 0; j < 8; j++) begin
            if (b0 + j < beats.size()) begin
                chk({tag, "_addr"}, {21'd0, beats[b0+j][10:8]}, j);
                chk({tag, "_data"}, {24'd0, beats[b0+j][7:0]},
                    {24'd0, sh[j]});
            end
        end
    endtask

    // mode 0: out_rdy high, 1: 3-cycle stall at beat 4, 2: random
    task automatic run_op(input bit c, input bit s, input int mode,
                          input bit hold, input string tag);
        int c0, b0, q0, d0, w0, held;
        bit ok;
        logic [7:0] hd;
        b0 = beats.size();
        q0 = cq.size();
        d0 = done_n;
        w0 = bad_wr;
        held = 0;
        ok = 1'b0;
        hd = 8'h00;
        clr = c;
        start = s;
        out_rdy = 1'b0;
        c0 = cyc_n;
        if (hold) begin
            wr_val  = 1'b1;
            wr_addr = 3'd5;
            wr_data = 8'h5a;
            sh[5]   = 8'h5a;
        end
        if (c) for (int j = 1; j < 8; j++) sh[j] = 8'h00;
        tick();
        clr = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) wr_val = 1'b0;
            if (done_n != d0) begin
                ok = 1'b1;
                break;
            end
            if (mode == 0) begin
                out_rdy = 1'b1;
            end else if (mode == 1) begin
                if (out_val && out_addr == 3'd4 && held < 3) begin
                    if (held == 0) hd = out_data;
                    out_rdy = 1'b0;
                    held++;
                    chk({tag, "_hold_addr"}, {29'd0, out_addr}, 4);
                    chk({tag, "_hold_data"}, {24'd0, out_data},
                        {24'd0, hd});
                end else begin
                    out_rdy = 1'b1;
                end
            end else begin
                out_rdy = 1'($urandom_range(0, 1));
            end
            tick();
        end
        out_rdy = 1'b0;
        wr_val = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, ok}, 1);
        if (mode == 0)
            chk({tag, "_done_time"}, done_cyc - c0, c ? 8 : 17);
        tick();
        chk({tag, "_done_once"}, done_n - d0, 1);
        chk({tag, "_wr_blocked"}, bad_wr - w0, 0);
        if (c) begin
            chk({tag, "_nclr"}, cq.size() - q0, 7);
            for (int j = 0; j < 7; j++)
                if (q0 + j < cq.size())
                    chk({tag, "_clr_wr"}, {21'd0, cq[q0+j]},
                        {21'd0, 3'(j + 1), 8'h00});
            chk({tag, "_no_beats"}, beats.size() - b0, 0);
        end else begin
            chk({tag, "_no_busy_wr"}, cq.size() - q0, 0);
            check_dump(tag, b0);
        end
        if (mode == 1) chk({tag, "_held"}, held, 3);
    endtask

    initial begin
        int d0;
        bit hit;
        for (int j = 0; j < 8; j++) sh[j] = 8'h00;
        reset   = 1'b0;
        clr     = 1'b0;
        start   = 1'b0;
        out_rdy = 1'b0;
        wr_val  = 1'b1;
        wr_addr = 3'd3;
        wr_data = 8'h77;
        #3;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_out_val", {31'd0, out_val}, 0);
        chk("rst_out_addr", {29'd0, out_addr}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_rd_addr", {29'd0, rf_read_addr}, 0);
        chk("rst_wr_rdy", {31'd0, wr_rdy}, 0);
        chk("rst_we", {31'd0, rf_write_en}, 0);
        chk("rst_waddr", {29'd0, rf_write_addr}, 0);
        chk("rst_wdata", {24'd0, rf_write_data}, 0);
        tick();
        tick();
        wr_val = 1'b0;
        reset = 1'b1;
        tick();

        wr(3'd1, 8'hab);
        wr(3'd2, 8'hcd);
        run_op(1'b0, 1'b1, 0, 1'b0, "pass");

        for (int j = 0; j < 8; j++) wr(3'(j), 8'hff);
        run_op(1'b1, 1'b0, 0, 1'b1, "clear");
        run_op(1'b0, 1'b1, 0, 1'b0, "cdump");

        wr(3'd4, 8'h3c);
        run_op(1'b0, 1'b1, 1, 1'b1, "bp");
        run_op(1'b1, 1'b1, 0, 1'b0, "prio");

        wr(3'd3, 8'h99);
        wr(3'd6, 8'h42);
        d0 = done_n;
        hit = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_val && out_addr == 3'd3) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("mrst_reach_b3", {31'd0, hit}, 1);
        reset = 1'b0;
        #1;
        chk("mrst_out_val", {31'd0, out_val}, 0);
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_wr_rdy", {31'd0, wr_rdy}, 0);
        tick();
        tick();
        reset = 1'b1;
        out_rdy = 1'b0;
        tick();
        tick();
        tick();
        chk("mrst_no_done", done_n - d0, 0);
        run_op(1'b0, 1'b1, 0, 1'b0, "restart");

        for (int i = 0; i < 40; i++) begin
            wr_val  = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom_range(0, 255));
            tick();
            if (wr_val && wr_addr != 3'd0) sh[wr_addr] = wr_data;
        end
        wr_val = 1'b0;
        run_op(1'b0, 1'b1, 2, 1'b0, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
